// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller.
//   - Segment/code constants used by the decoder and the frame buffers.
//   - Scan FSM state type.
//   - idx_width(): counter/index width helper that never returns 0.
package seg7_scan_ctrl_pkg;

    localparam logic [7:0] SEG_BLANK  = 8'hFF;   // active-low: all segments off
    localparam logic [3:0] CODE_BLANK = 4'hF;

    // Special glyph codes shown by the Sudoku board.
    localparam logic [3:0] CODE_A = 4'hA;
    localparam logic [3:0] CODE_B = 4'hB;
    localparam logic [3:0] CODE_C = 4'hC;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    // Width needed to hold values 0..n-1, at least one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_lut.sv
// SEG7_LUT decoder: 4-bit code to active-low segment pattern {dp,g,f,e,d,c,b,a}.
//   code_i : 4-bit digit code (0-9 digits, A/B/C glyphs, D/E/F blank)
//   seg_o  : active-low segment pattern, purely combinational
module seg7_scan_ctrl_lut
    import seg7_scan_ctrl_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (code_i)
            4'h0:    seg_o = 8'hC0;
            4'h1:    seg_o = 8'hF9;
            4'h2:    seg_o = 8'hA4;
            4'h3:    seg_o = 8'hB0;
            4'h4:    seg_o = 8'h99;
            4'h5:    seg_o = 8'h92;
            4'h6:    seg_o = 8'h82;
            4'h7:    seg_o = 8'hF8;
            4'h8:    seg_o = 8'h80;
            4'h9:    seg_o = 8'h90;
            CODE_A:  seg_o = 8'hC7;
            CODE_B:  seg_o = 8'hC6;
            CODE_C:  seg_o = 8'hB6;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scan controller.
// Each digit slot is PRESCALE cycles: BLANK_CYC cycles with every digit off
// (anti-ghosting), then the remainder driving one digit. New frames arrive via
// a one-deep pending buffer and are swapped into the active buffer only at the
// frame wrap, so a frame is never shown half old / half new.
//   iCLK, iRST       : clock, asynchronous active-high reset
//   iFRAME           : NUM_DIG 4-bit codes, digit i at [4i+3:4i]
//   iFRAME_VALID     : frame offer; oFRAME_READY : pending buffer free
//   iBLINK_EN/MASK   : global blink enable and per-digit blink select
//   oSEG             : registered active-low segments {dp,g,f,e,d,c,b,a}
//   oDIG_N           : registered active-low digit enables (one-hot or all ones)
//   oSCAN_IDX        : digit currently owning the slot
//   oFRAME_DONE      : one-cycle pulse in the first cycle after a frame wrap
module seg7_scan_ctrl
    import seg7_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIG      = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYC    = 500,
    parameter int BLINK_FRAMES = 64,
    localparam int IDX_W       = idx_width(NUM_DIG)
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic [4*NUM_DIG-1:0] iFRAME,
    input  logic                 iFRAME_VALID,
    output logic                 oFRAME_READY,
    input  logic                 iBLINK_EN,
    input  logic [NUM_DIG-1:0]   iBLINK_MASK,
    output logic [7:0]           oSEG,
    output logic [NUM_DIG-1:0]   oDIG_N,
    output logic [IDX_W-1:0]     oSCAN_IDX,
    output logic                 oFRAME_DONE
);

    localparam int CNT_W = idx_width(PRESCALE);
    localparam int BLK_W = idx_width(BLINK_FRAMES);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(PRESCALE - BLANK_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIG - 1);
    localparam logic [BLK_W-1:0] BLK_LAST   = BLK_W'(BLINK_FRAMES - 1);

    scan_state_t          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [BLK_W-1:0]     blink_cnt_q, blink_cnt_d;
    logic                 phase_q, phase_d;
    logic [4*NUM_DIG-1:0] active_q, active_d;
    logic [4*NUM_DIG-1:0] pend_q, pend_d;
    logic                 pend_full_q, pend_full_d;
    logic [7:0]           seg_q, seg_d;
    logic [NUM_DIG-1:0]   dig_n_q, dig_n_d;
    logic                 done_q, done_d;

    logic                 accept;
    logic                 wrap;
    logic                 blank_now;
    logic [3:0]           digit_code [NUM_DIG];
    logic [7:0]           lut_seg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIG; gi++) begin : g_dig
            assign digit_code[gi] = active_q[4*gi +: 4];
            // Enables follow the next state so digit and segments switch on
            // the same edge (idx never changes on a BLANK->DRIVE transition).
            assign dig_n_d[gi] = !((state_d == DRIVE) && (idx_q == IDX_W'(gi)));
        end
    endgenerate

    seg7_scan_ctrl_lut u_lut (
        .code_i (digit_code[idx_q]),
        .seg_o  (lut_seg)
    );

    assign accept    = iFRAME_VALID && !pend_full_q;
    assign blank_now = iBLINK_EN && iBLINK_MASK[idx_q] && phase_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        idx_d       = idx_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        active_d    = active_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        done_d      = 1'b0;
        wrap        = 1'b0;
        seg_d       = SEG_BLANK;

        case (state_q)
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = DRIVE;
                    cnt_d   = '0;
                end
            end
            DRIVE: begin
                if (cnt_q == DRIVE_LAST) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                        wrap  = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = BLANK;
        endcase

        if (wrap) begin
            done_d = 1'b1;
            if (blink_cnt_q == BLK_LAST) begin
                blink_cnt_d = '0;
                phase_d     = !phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLK_W'(1);
            end
            if (pend_full_q) begin
                active_d    = pend_q;
                pend_full_d = 1'b0;
            end
        end

        // Accept only happens with pending empty, so it never collides with a
        // swap: a frame taken on the wrap edge waits for the following wrap.
        if (accept) begin
            pend_d      = iFRAME;
            pend_full_d = 1'b1;
        end

        if (state_d == DRIVE && !blank_now) begin
            seg_d = lut_seg;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q     <= BLANK;
            cnt_q       <= '0;
            idx_q       <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            active_q    <= {NUM_DIG{CODE_BLANK}};
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            seg_q       <= SEG_BLANK;
            dig_n_q     <= '1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            active_q    <= active_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            seg_q       <= seg_d;
            dig_n_q     <= dig_n_d;
            done_q      <= done_d;
        end
    end

    assign oFRAME_READY = !pend_full_q;
    assign oSEG         = seg_q;
    assign oDIG_N       = dig_n_q;
    assign oSCAN_IDX    = idx_q;
    assign oFRAME_DONE  = done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl (NUM_DIG=4, PRESCALE=8, BLANK_CYC=2,
// BLINK_FRAMES=2). The stimulus process pushes the expected contents of every
// digit slot; the monitor pops one entry whenever a digit enable goes active.
module tb_seg7_scan_ctrl;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic [15:0] iFRAME;
    logic        iFRAME_VALID;
    logic        oFRAME_READY;
    logic        iBLINK_EN;
    logic [3:0]  iBLINK_MASK;
    logic [7:0]  oSEG;
    logic [3:0]  oDIG_N;
    logic [1:0]  oSCAN_IDX;
    logic        oFRAME_DONE;

    bit clk_run = 1'b0;
    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] dig_n;
        logic [7:0] seg;
        logic [1:0] idx;
    } exp_t;

    exp_t exp_q[$];

    seg7_scan_ctrl #(
        .NUM_DIG      (4),
        .PRESCALE     (8),
        .BLANK_CYC    (2),
        .BLINK_FRAMES (2)
    ) dut (
        .iCLK         (iCLK),
        .iRST         (iRST),
        .iFRAME       (iFRAME),
        .iFRAME_VALID (iFRAME_VALID),
        .oFRAME_READY (oFRAME_READY),
        .iBLINK_EN    (iBLINK_EN),
        .iBLINK_MASK  (iBLINK_MASK),
        .oSEG         (oSEG),
        .oDIG_N       (oDIG_N),
        .oSCAN_IDX    (oSCAN_IDX),
        .oFRAME_DONE  (oFRAME_DONE)
    );

    always begin
        #5;
        if (clk_run) iCLK = ~iCLK;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic push_frame(input logic [7:0] s0, input logic [7:0] s1,
                              input logic [7:0] s2, input logic [7:0] s3);
        exp_q.push_back('{4'b1110, s0, 2'd0});
        exp_q.push_back('{4'b1101, s1, 2'd1});
        exp_q.push_back('{4'b1011, s2, 2'd2});
        exp_q.push_back('{4'b0111, s3, 2'd3});
    endtask

    // Returns at the negedge of the first cycle of a new frame.
    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge iCLK);
            n++;
        end while (!oFRAME_DONE && n < 40);
        chk("frame_done_seen", {31'd0, oFRAME_DONE}, 32'd1);
    endtask

    // Monitor: one scoreboard pop per digit slot, plus per-cycle slot checks.
    initial begin : monitor
        exp_t cur;
        bit   in_slot  = 1'b0;
        int   run      = 0;
        int   cyc      = 0;
        int   last_done = -1;
        cur = '{4'hF, 8'hFF, 2'd0};
        forever begin
            @(negedge iCLK);
            cyc++;
            if (iRST) begin
                in_slot   = 1'b0;
                run       = 0;
                last_done = -1;
            end else begin
                if (oDIG_N != 4'hF) begin
                    if (!in_slot) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL slot_underflow: got dig_n=%b seg=%h, expected no slot", oDIG_N, oSEG);
                            cur = '{4'hF, 8'hFF, 2'd0};
                        end else begin
                            cur = exp_q.pop_front();
                            $display("slot idx=%0d dig_n=%b seg=%h (expected %b/%h)",
                                     oSCAN_IDX, oDIG_N, oSEG, cur.dig_n, cur.seg);
                        end
                        in_slot = 1'b1;
                        run     = 0;
                        chk("scan_idx", {30'd0, oSCAN_IDX}, {30'd0, cur.idx});
                    end
                    run++;
                    chk("dig_n", {28'd0, oDIG_N}, {28'd0, cur.dig_n});
                    chk("seg", {24'd0, oSEG}, {24'd0, cur.seg});
                end else begin
                    chk("blank_seg", {24'd0, oSEG}, 32'hFF);
                    if (in_slot) begin
                        chk("drive_len", run, 32'd6);
                        in_slot = 1'b0;
                    end
                end
                if (oFRAME_DONE) begin
                    if (last_done >= 0) chk("done_period", cyc - last_done, 32'd32);
                    last_done = cyc;
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : stimulus
        int n;
        iRST = 1'b0; iFRAME = '0; iFRAME_VALID = 1'b0;
        iBLINK_EN = 1'b0; iBLINK_MASK = '0;

        // Reset with no clock running.
        #3 iRST = 1'b1;
        #1;
        chk("rst_seg",   {24'd0, oSEG}, 32'hFF);
        chk("rst_dig_n", {28'd0, oDIG_N}, 32'hF);
        chk("rst_ready", {31'd0, oFRAME_READY}, 32'd1);
        chk("rst_done",  {31'd0, oFRAME_DONE}, 32'd0);
        chk("rst_idx",   {30'd0, oSCAN_IDX}, 32'd0);

        clk_run = 1'b1;
        repeat (2) @(negedge iCLK);

        // Frame 0: active still all F. Offer 3210 immediately.
        push_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        iRST = 1'b0; iFRAME = 16'h3210; iFRAME_VALID = 1'b1;
        @(negedge iCLK);
        iFRAME_VALID = 1'b0;

        // Frame 1 shows 3210; load 4444 then hold 5555 under backpressure.
        wait_done();
        push_frame(8'hC0, 8'hF9, 8'hA4, 8'hB0);
        iFRAME = 16'h4444; iFRAME_VALID = 1'b1;
        @(negedge iCLK);
        chk("ready_low_pending", {31'd0, oFRAME_READY}, 32'd0);
        iFRAME = 16'h5555;
        n = 0;
        while (!oFRAME_READY && n < 40) begin
            @(negedge iCLK);
            n++;
        end
        chk("ready_after_wrap", {31'd0, oFRAME_READY}, 32'd1);
        chk("ready_with_done",  {31'd0, oFRAME_DONE}, 32'd1);
        // Frame 2 shows 4444; held 5555 is taken on the coming edge.
        push_frame(8'h99, 8'h99, 8'h99, 8'h99);
        @(negedge iCLK);
        iFRAME_VALID = 1'b0;
        chk("held_offer_taken", {31'd0, oFRAME_READY}, 32'd0);

        // Frame 3 shows 5555; offer 9876 exactly on the wrap edge.
        wait_done();
        push_frame(8'h92, 8'h92, 8'h92, 8'h92);
        repeat (31) @(negedge iCLK);
        iFRAME = 16'h9876; iFRAME_VALID = 1'b1;
        @(negedge iCLK);
        chk("wrap_edge_done",   {31'd0, oFRAME_DONE}, 32'd1);
        chk("wrap_edge_accept", {31'd0, oFRAME_READY}, 32'd0);
        iFRAME_VALID = 1'b0;
        // Frame 4 still shows 5555 (no swap on the accept edge).
        push_frame(8'h92, 8'h92, 8'h92, 8'h92);

        // Frame 5 shows 9876; load 8888 for the blink test.
        wait_done();
        push_frame(8'h82, 8'hF8, 8'h80, 8'h90);
        iFRAME = 16'h8888; iFRAME_VALID = 1'b1;
        @(negedge iCLK);
        iFRAME_VALID = 1'b0;

        // Frames 6,7 blink phase 1: digit 1 blank. Frames 8,9 phase 0.
        wait_done();
        iBLINK_EN = 1'b1; iBLINK_MASK = 4'b0010;
        push_frame(8'h80, 8'hFF, 8'h80, 8'h80);
        wait_done();
        push_frame(8'h80, 8'hFF, 8'h80, 8'h80);
        wait_done();
        push_frame(8'h80, 8'h80, 8'h80, 8'h80);
        wait_done();
        push_frame(8'h80, 8'h80, 8'h80, 8'h80);
        iFRAME = 16'hECBA; iFRAME_VALID = 1'b1;
        @(negedge iCLK);
        iFRAME_VALID = 1'b0;

        // Frame 10: glyphs A/B/C/E with blinking disabled.
        wait_done();
        iBLINK_EN = 1'b0;
        push_frame(8'hC7, 8'hC6, 8'hB6, 8'hFF);

        // Frame 11: fill pending, then reset mid-DRIVE of digit 2.
        wait_done();
        exp_q.push_back('{4'b1110, 8'hC7, 2'd0});
        exp_q.push_back('{4'b1101, 8'hC6, 2'd1});
        exp_q.push_back('{4'b1011, 8'hB6, 2'd2});
        iFRAME = 16'h1111; iFRAME_VALID = 1'b1;
        @(negedge iCLK);
        iFRAME_VALID = 1'b0;
        chk("pending_full", {31'd0, oFRAME_READY}, 32'd0);
        repeat (19) @(negedge iCLK);
        #2 iRST = 1'b1;
        #1;
        chk("midrst_seg",   {24'd0, oSEG}, 32'hFF);
        chk("midrst_dig_n", {28'd0, oDIG_N}, 32'hF);
        chk("midrst_ready", {31'd0, oFRAME_READY}, 32'd1);
        chk("midrst_idx",   {30'd0, oSCAN_IDX}, 32'd0);
        chk("midrst_done",  {31'd0, oFRAME_DONE}, 32'd0);
        @(negedge iCLK);
        @(negedge iCLK);

        // After reset: active all F, pending 1111 was lost.
        push_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        iRST = 1'b0;
        wait_done();
        push_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        wait_done();
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexed driver for a bank of common-anode 7-segment digits that share one segment bus.
- Holds one displayed frame of 4-bit codes and scans the digits round-robin through a single shared SEG7_LUT decoder.
- Inserts a blanking gap between digits to prevent ghosting, and accepts new frames through a valid/ready handshake without tearing.
- Supports per-digit blinking. Sits between the Sudoku game logic and the board display pins.

Parameters:
- NUM_DIG, 4, number of digits scanned (legal range 1..8).
- PRESCALE, 50000, clock cycles per digit slot (must be > BLANK_CYC).
- BLANK_CYC, 500, cycles at the start of each slot with all digits off (≥1).
- BLINK_FRAMES, 64, full scan frames per blink half-period (≥1).

Ports:
- iCLK  in  1  system clock.
- iRST  in  1  reset; asynchronous, active-high.
- iFRAME  in  4*NUM_DIG  digit codes; digit i = iFRAME[4i+3:4i].
- iFRAME_VALID  in  1  frame offer.
- oFRAME_READY  out  1  pending slot free.
- iBLINK_EN  in  1  global blink enable.
- iBLINK_MASK  in  NUM_DIG  bit i=1 makes digit i blink.
- oSEG  out  8  active-low segments {dp,g,f,e,d,c,b,a}, registered.
- oDIG_N  out  NUM_DIG  active-low digit enables, one-hot or all-ones, registered.
- oSCAN_IDX  out  clog2(NUM_DIG) (min 1)  digit currently in slot.
- oFRAME_DONE  out  1  one-cycle pulse at each frame wrap.

Behaviour:
- Reset (async, takes effect without a clock):
  - State BLANK, idx=0, slot counter 0, blink counter 0, blink phase 0.
  - Active buffer all 4'hF; pending empty.
  - oFRAME_READY=1, oSEG=8'hFF, oDIG_N all ones, oFRAME_DONE=0.
- Handshake:
  - Accept on the edge where iFRAME_VALID & oFRAME_READY; iFRAME is copied into pending and pending becomes full.
  - oFRAME_READY = !pending_full.
  - A held offer (VALID=1, READY=0) is never dropped; it is accepted on the first edge READY=1.
- FSM, with slot counter cnt:
  - BLANK: oDIG_N all ones, oSEG=8'hFF. When cnt==BLANK_CYC-1: go to DRIVE, cnt=0.
  - DRIVE: oDIG_N[idx]=0, others 1; oSEG=decode(active[idx]), or 8'hFF if blanked. When cnt==PRESCALE-BLANK_CYC-1: go to BLANK, cnt=0, idx=idx+1 (wraps NUM_DIG-1→0).
  - oSEG and oDIG_N change on the same edge: first DRIVE cycle shows digit and segments together; first BLANK cycle clears both.
- Decode:
  - Through one instance of the shared decoder: 0-9 digits; A/B/C special glyphs; D/E/F blank (8'hFF).
  - Decoder output is registered with the FSM outputs; no extra latency beyond one edge.
- Frame wrap (DRIVE, idx=NUM_DIG-1 → BLANK, idx=0):
  - If pending full: active←pending, pending emptied.
  - oFRAME_DONE pulses in the first cycle of the new BLANK.
  - Blink counter increments; at BLINK_FRAMES-1 it clears and blink phase toggles.
- Swap on accept edge: if accept and wrap fall on the same edge, swap uses the old pending contents (empty → no swap). The new frame is stored in pending and swaps at the next wrap. READY goes low the cycle after that edge.
- Blank condition: iBLINK_EN & iBLINK_MASK[idx] & phase. Blink inputs are sampled live each cycle.
- Slot period is exactly PRESCALE cycles; frame period is NUM_DIG*PRESCALE.
- Reset mid-DRIVE: outputs go to reset values immediately and pending is lost.

Decomposition:
- Shared package:
  - Constants SEG_BLANK=8'hFF and CODE_BLANK=4'hF.
  - Glyph codes CODE_A/B/C.
  - FSM state typedef {BLANK, DRIVE}.
  - clog2 helper for the idx width.
- One sub-module: the existing SEG7_LUT decoder, instantiated once and fed by active[idx]. Everything else is inline: counters, FSM, buffers.

Test Plan:
All tests use NUM_DIG=4, PRESCALE=8, BLANK_CYC=2, BLINK_FRAMES=2.
1. Reset: assert iRST without a clock edge → oSEG=FF, oDIG_N=1111, oFRAME_READY=1, oFRAME_DONE=0. After release, first DRIVE shows active=F → oSEG=FF with oDIG_N=1110 at cycle 2.
2. Load iFRAME=16'h3210 in the first frame → after the wrap, slot 0 cycles 2-7 give oDIG_N=1110/oSEG=C0. Slot 1 gives 1101/F9, slot 2 gives 1011/A4, slot 3 gives 0111/B0. Slot cycles 0-1 give 1111/FF. oFRAME_DONE pulses every 32 cycles.
3. Backpressure: offer 16'h4444, then hold VALID with 16'h5555 → READY=0 until wrap. Next frame shows 4 (99); 5555 is accepted after the wrap and shown (92) one frame later; no frame is lost.
4. Same-edge accept and wrap with pending empty → the new frame appears one frame later, not immediately.
5. Blink: iBLINK_EN=1, mask=4'b0010, frame 16'h8888 → digit 1 alternates 80 for 2 frames and FF for 2 frames; digits 0, 2, 3 stay 80.
6. Codes A/B/C/E → C7/C6/B6/FF. Assert iRST mid-DRIVE of digit 2 → outputs go to FF/1111 asynchronously and idx returns to 0.
